// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: issues word requests under a credit limit, pairs in-order responses
// with their PCs in a small buffer for decode, and squashes stale responses after a redirect.
module fetch_ctrl #(
  parameter int unsigned       AWIDTH   = 32,
  parameter int unsigned       DWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [AWIDTH-1:0] mem_req_addr_o,
  input  logic              mem_rsp_valid_i,
  input  logic [DWIDTH-1:0] mem_rsp_data_i,
  output logic              insn_valid_o,
  input  logic              insn_ready_i,
  output logic [DWIDTH-1:0] insn_o,
  output logic [AWIDTH-1:0] pc_o,
  input  logic              redirect_valid_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  input  logic              halt_i,
  output logic              misalign_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {StBoot, StRun, StHalt, StFlush, StErr} state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] next_pc_q, next_pc_d;
  logic [CW-1:0]     infl_q, infl_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic              misalign_q, misalign_d;

  logic [DWIDTH-1:0] buf_insn_q [DEPTH];
  logic [DWIDTH-1:0] buf_insn_d [DEPTH];
  logic [AWIDTH-1:0] buf_pc_q   [DEPTH];
  logic [AWIDTH-1:0] buf_pc_d   [DEPTH];
  logic [PW-1:0]     buf_head_q, buf_head_d, buf_tail_q, buf_tail_d;
  logic [CW-1:0]     buf_cnt_q, buf_cnt_d;

  logic [AWIDTH-1:0] pcq_q [DEPTH];
  logic [AWIDTH-1:0] pcq_d [DEPTH];
  logic [PW-1:0]     pcq_head_q, pcq_head_d, pcq_tail_q, pcq_tail_d;

  logic credit_ok, req_valid, hs, rsp, redir_ok, redir_bad, flush, buf_push, buf_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Credits count words owed by memory plus words buffered; no bypass of a same-cycle pop.
  assign credit_ok = (SW'(infl_q) + SW'(buf_cnt_q)) < SW'(DEPTH);
  assign req_valid = (state_q == StRun) && !halt_i && credit_ok;
  assign hs        = req_valid && mem_req_ready_i;
  // A response with nothing outstanding (e.g. a request from before reset) is ignored.
  assign rsp       = mem_rsp_valid_i && (infl_q != '0);
  assign redir_bad = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
  assign redir_ok  = redirect_valid_i && !redir_bad && (state_q != StErr);
  assign flush     = redir_ok || redir_bad;
  assign buf_push  = rsp && (drop_q == '0) && (state_q != StErr) && !flush;
  assign buf_pop   = (buf_cnt_q != '0) && insn_ready_i && !flush;

  always_comb begin
    state_d    = state_q;
    next_pc_d  = next_pc_q;
    misalign_d = misalign_q | redir_bad;
    infl_d     = infl_q + CW'(hs) - CW'(rsp);
    drop_d     = drop_q;

    if (rsp && (drop_q != '0)) drop_d = drop_q - CW'(1);
    if (hs) next_pc_d = next_pc_q + AWIDTH'(4);
    // Everything still owed, including a request accepted this cycle, becomes stale.
    if (flush) begin
      drop_d = infl_d;
    end
    if (redir_ok) next_pc_d = redirect_pc_i;

    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun: begin
        if (redir_ok)    state_d = (infl_d != '0) ? StFlush : StRun;
        else if (halt_i) state_d = StHalt;
      end
      StHalt: begin
        if (redir_ok)     state_d = (infl_d != '0) ? StFlush : StRun;
        else if (!halt_i) state_d = StRun;
      end
      StFlush: begin
        if (redir_ok)            state_d = (infl_d != '0) ? StFlush : StRun;
        else if (drop_d == '0)   state_d = StRun;
      end
      StErr:   state_d = StErr;
      default: state_d = StErr;
    endcase
    if (redir_bad) state_d = StErr;
  end

  always_comb begin
    buf_insn_d = buf_insn_q;
    buf_pc_d   = buf_pc_q;
    buf_head_d = buf_head_q;
    buf_tail_d = buf_tail_q;
    buf_cnt_d  = buf_cnt_q;
    pcq_d      = pcq_q;
    pcq_head_d = pcq_head_q;
    pcq_tail_d = pcq_tail_q;

    if (flush) begin
      buf_head_d = '0;
      buf_tail_d = '0;
      buf_cnt_d  = '0;
      pcq_head_d = '0;
      pcq_tail_d = '0;
    end else begin
      if (buf_push) begin
        buf_insn_d[buf_tail_q] = mem_rsp_data_i;
        buf_pc_d[buf_tail_q]   = pcq_q[pcq_head_q];
        buf_tail_d             = ptr_inc(buf_tail_q);
        pcq_head_d             = ptr_inc(pcq_head_q);
      end
      if (buf_pop) buf_head_d = ptr_inc(buf_head_q);
      buf_cnt_d = buf_cnt_q + CW'(buf_push) - CW'(buf_pop);
      if (hs) begin
        pcq_d[pcq_tail_q] = next_pc_q;
        pcq_tail_d        = ptr_inc(pcq_tail_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StBoot;
      next_pc_q  <= BASEADDR;
      infl_q     <= '0;
      drop_q     <= '0;
      misalign_q <= 1'b0;
      buf_head_q <= '0;
      buf_tail_q <= '0;
      buf_cnt_q  <= '0;
      pcq_head_q <= '0;
      pcq_tail_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        buf_insn_q[i] <= '0;
        buf_pc_q[i]   <= '0;
        pcq_q[i]      <= '0;
      end
    end else begin
      state_q    <= state_d;
      next_pc_q  <= next_pc_d;
      infl_q     <= infl_d;
      drop_q     <= drop_d;
      misalign_q <= misalign_d;
      buf_head_q <= buf_head_d;
      buf_tail_q <= buf_tail_d;
      buf_cnt_q  <= buf_cnt_d;
      pcq_head_q <= pcq_head_d;
      pcq_tail_q <= pcq_tail_d;
      buf_insn_q <= buf_insn_d;
      buf_pc_q   <= buf_pc_d;
      pcq_q      <= pcq_d;
    end
  end

  assign mem_req_valid_o = req_valid;
  assign mem_req_addr_o  = next_pc_q;
  assign insn_valid_o    = (buf_cnt_q != '0);
  assign insn_o          = buf_insn_q[buf_head_q];
  assign pc_o            = buf_pc_q[buf_head_q];
  assign misalign_o      = misalign_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(buf_push && !buf_pop && (buf_cnt_q == CW'(DEPTH))));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl: an in-order memory with random latency and a transaction-level
// model (queue of accepted, not-yet-squashed request PCs) predicting what decode must receive.
module tb_fetch_ctrl;
  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid_o, mem_req_ready_i;
  logic [31:0] mem_req_addr_o;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rsp_data_i;
  logic        insn_valid_o, insn_ready_i;
  logic [31:0] insn_o, pc_o;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        halt_i, misalign_o;

  always #5 clk = ~clk;

  fetch_ctrl #(.AWIDTH(32), .DWIDTH(32), .BASEADDR(BASE), .DEPTH(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_rsp_valid_i  (mem_rsp_valid_i),
    .mem_rsp_data_i   (mem_rsp_data_i),
    .insn_valid_o     (insn_valid_o),
    .insn_ready_i     (insn_ready_i),
    .insn_o           (insn_o),
    .pc_o             (pc_o),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .halt_i           (halt_i),
    .misalign_o       (misalign_o)
  );

  typedef struct packed {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          last_due = 0;
  int          hs_cnt = 0;
  logic [31:0] mq[$];     // accepted requests whose words decode must still receive, in order
  mreq_t       memq[$];   // responses the memory still owes
  logic [31:0] hs_log[$];
  logic [31:0] pop_log[$];
  logic [31:0] m_pc;
  bit          m_err = 0;
  bit          prev_redir = 0, prev_pending = 0, prev_halt = 0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive the memory response, sample just before the edge, update the model.
  task automatic tick();
    bit    hs, pop, rsp_now;
    mreq_t r;
    rsp_now = !rst && (memq.size() > 0) && (memq[0].due <= cyc);
    mem_rsp_valid_i = rsp_now;
    mem_rsp_data_i  = rsp_now ? word_of(memq[0].addr) : 32'h0;
    #1;
    hs  = mem_req_valid_o && mem_req_ready_i;
    pop = insn_valid_o && insn_ready_i;
    if (rst) begin
      mq.delete();
      memq.delete();
      m_pc = BASE;
      m_err = 0;
      last_due = cyc;
    end else begin
      if (rsp_now) void'(memq.pop_front());
      if (m_err) begin
        check("err_req_valid", 32'(mem_req_valid_o), 32'd0);
        check("err_misalign", 32'(misalign_o), 32'd1);
        check("err_insn_valid", 32'(insn_valid_o), 32'd0);
      end
      if (halt_i) check("halt_no_req", 32'(mem_req_valid_o), 32'd0);
      if (prev_redir) check("redir_insn_valid", 32'(insn_valid_o), 32'd0);
      if (prev_pending && !prev_redir && !prev_halt && !halt_i) begin
        check("req_hold_valid", 32'(mem_req_valid_o), 32'd1);
        check("req_hold_addr", mem_req_addr_o, prev_addr);
      end
      if (pop) begin
        if (mq.size() == 0) begin
          check("insn_unexpected", 32'(insn_valid_o), 32'd0);
        end else begin
          check("insn_pc", pc_o, mq[0]);
          check("insn_word", insn_o, word_of(mq[0]));
          void'(mq.pop_front());
        end
        pop_log.push_back(pc_o);
      end
      if (hs) begin
        check("req_addr", mem_req_addr_o, m_pc);
        r.addr = m_pc;
        r.due  = cyc + lat_min + int'($urandom_range(0, lat_max - lat_min));
        if (r.due <= last_due) r.due = last_due + 1;
        last_due = r.due;
        memq.push_back(r);
        mq.push_back(m_pc);
        hs_log.push_back(mem_req_addr_o);
        hs_cnt++;
        m_pc = m_pc + 32'd4;
      end
      if (redirect_valid_i && !m_err) begin
        mq.delete();
        if (redirect_pc_i[1:0] != 2'b00) m_err = 1;
        else m_pc = redirect_pc_i;
      end
    end
    prev_redir   = redirect_valid_i && !rst;
    prev_pending = mem_req_valid_o && !mem_req_ready_i && !rst;
    prev_halt    = halt_i;
    prev_addr    = mem_req_addr_o;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_req_ready_i  = 1'b0;
    insn_ready_i     = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = '0;
    halt_i           = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_req_valid", 32'(mem_req_valid_o), 32'd0);
    check("rst_insn_valid", 32'(insn_valid_o), 32'd0);
    check("rst_misalign", 32'(misalign_o), 32'd0);
    check("rst_req_addr", mem_req_addr_o, BASE);
    check("rst_insn", insn_o, 32'd0);
    check("rst_pc", pc_o, 32'd0);
  endtask

  task automatic wait_hs(input string tag, input int n);
    int k = 0;
    while (hs_cnt < n && k < 100) begin
      tick();
      k++;
    end
    if (hs_cnt < n) check(tag, 32'(hs_cnt), 32'(n));
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = pc;
    tick();
    redirect_valid_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    m_pc = BASE;

    // Straight-line fetch with a 1-cycle memory.
    do_reset();
    lat_min = 1; lat_max = 1;
    mem_req_ready_i = 1'b1;
    insn_ready_i    = 1'b1;
    tick();
    check("first_req_valid", 32'(mem_req_valid_o), 32'd1);
    check("first_req_addr", mem_req_addr_o, BASE);
    hs_log.delete(); pop_log.delete(); hs_cnt = 0;
    repeat (14) tick();
    if (hs_log.size() >= 3) begin
      check("seq_addr1", hs_log[1], BASE + 32'd4);
      check("seq_addr2", hs_log[2], BASE + 32'd8);
    end else check("seq_count", 32'(hs_log.size()), 32'd3);
    check("seq_delivered", 32'(pop_log.size() >= 4), 32'd1);

    // Decode stalled: credits stop issue after DEPTH words.
    do_reset();
    mem_req_ready_i = 1'b1;
    insn_ready_i    = 1'b0;
    hs_cnt = 0; hs_log.delete();
    repeat (10) tick();
    check("stall_req_count", 32'(hs_cnt), 32'd2);
    check("stall_req_valid", 32'(mem_req_valid_o), 32'd0);
    insn_ready_i = 1'b1;
    hs_cnt = 0; hs_log.delete();
    wait_hs("stall_resume_timeout", 1);
    if (hs_log.size() > 0) check("stall_resume_addr", hs_log[0], BASE + 32'd8);
    repeat (6) tick();

    // Redirect with one response owed: the stale word is squashed.
    do_reset();
    lat_min = 4; lat_max = 4;
    mem_req_ready_i = 1'b1;
    insn_ready_i    = 1'b1;
    tick();
    tick();
    mem_req_ready_i = 1'b0;
    redirect(32'h0100_0100);
    mem_req_ready_i = 1'b1;
    k = 0;
    while (memq.size() > 0 && k < 20) begin
      check("flush_no_req", 32'(mem_req_valid_o), 32'd0);
      tick();
      k++;
    end
    check("flush_drained", 32'(memq.size()), 32'd0);
    hs_cnt = 0; hs_log.delete(); pop_log.delete();
    wait_hs("flush_resume_timeout", 1);
    if (hs_log.size() > 0) check("flush_new_addr", hs_log[0], 32'h0100_0100);
    repeat (12) tick();
    if (pop_log.size() > 0) check("flush_first_pc", pop_log[0], 32'h0100_0100);
    else check("flush_delivered", 32'(pop_log.size()), 32'd1);

    // Redirect in the same cycle as a response.
    do_reset();
    lat_min = 2; lat_max = 2;
    mem_req_ready_i = 1'b1;
    insn_ready_i    = 1'b1;
    tick();
    k = 0;
    while (!(memq.size() > 0 && memq[0].due == cyc) && k < 20) begin
      tick();
      k++;
    end
    check("coinc_rsp_pending", 32'(memq.size() > 0), 32'd1);
    redirect(32'h0100_0200);
    hs_cnt = 0; hs_log.delete(); pop_log.delete();
    wait_hs("coinc_resume_timeout", 1);
    if (hs_log.size() > 0) check("coinc_new_addr", hs_log[0], 32'h0100_0200);
    repeat (12) tick();
    if (pop_log.size() > 0) check("coinc_first_pc", pop_log[0], 32'h0100_0200);
    else check("coinc_delivered", 32'(pop_log.size()), 32'd1);

    // Misaligned target: sticky error, issue stops until reset.
    do_reset();
    lat_min = 1; lat_max = 1;
    mem_req_ready_i = 1'b1;
    insn_ready_i    = 1'b1;
    repeat (5) tick();
    redirect(32'h0100_0102);
    hs_cnt = 0;
    repeat (15) tick();
    check("misalign_flag", 32'(misalign_o), 32'd1);
    check("misalign_no_req", 32'(hs_cnt), 32'd0);

    // Address wrap at the top of the space.
    do_reset();
    mem_req_ready_i = 1'b1;
    insn_ready_i    = 1'b1;
    repeat (3) tick();
    redirect(32'hFFFF_FFFC);
    hs_cnt = 0; hs_log.delete();
    wait_hs("wrap_timeout", 2);
    if (hs_log.size() >= 2) begin
      check("wrap_addr0", hs_log[0], 32'hFFFF_FFFC);
      check("wrap_addr1", hs_log[1], 32'h0000_0000);
    end
    repeat (10) tick();

    // Randomized traffic: backpressure, halts, redirects, latency, occasional reset.
    do_reset();
    lat_min = 1; lat_max = 4;
    k = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 999) do_reset();
      mem_req_ready_i = ($urandom_range(0, 3) != 0);
      insn_ready_i    = ($urandom_range(0, 3) != 0);
      if (k > 0) begin
        halt_i = 1'b1;
        k--;
      end else begin
        halt_i = 1'b0;
        if ($urandom_range(0, 49) == 0) k = int'($urandom_range(1, 6));
      end
      redirect_valid_i = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 2))
        0:       redirect_pc_i = $urandom & 32'hFFFF_FFFC;
        1:       redirect_pc_i = 32'hFFFF_FFF8;
        default: redirect_pc_i = BASE + ($urandom_range(0, 255) << 2);
      endcase
      tick();
    end
    redirect_valid_i = 1'b0;
    halt_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
